fault_logger: RTL
=================

# fault_logger

Downstream consumer of the state monitor's `o_valid` line. It counts invalid (transient) periods and measures each period's length in coarse ticks. Completed durations are pushed into a small FIFO that the host drains with a read strobe on a pin. It gives the tile a readable history of transients instead of only the live valid flag.

## Interface
Parameters:
- `TICK_DIV`, default 16'd10000: clock cycles per duration tick (1 s at the 10 kHz tile clock); legal range 1..65535.
- `DEPTH`, default 4: FIFO entries; power of two, 2..16.

Ports:
- `i_clk` input 1: clock.
- `i_rst_n` input 1: reset, asynchronous, active-low.
- `i_valid` input 1: monitor valid flag, same clock domain, no synchroniser.
- `i_rd` input 1: read strobe from pin (asynchronous level); each rising edge pops one entry.
- `i_clear` input 1: synchronous one-cycle clear.
- `o_fault_active` output 1: high while an invalid period is being measured.
- `o_event_count` output 8: number of invalid periods entered, saturating at 255.
- `o_data` output 8: FIFO head duration in ticks; 8'd0 when empty.
- `o_empty` output 1: FIFO empty.
- `o_full` output 1: FIFO full.
- `o_overflow` output 1: sticky flag, set when a push was dropped.
- `o_max_dur` output 8: longest recorded duration (see Configuration).

## Operation
- FSM states: IDLE and FAULT.
- IDLE, `i_valid`=0: go to FAULT, zero the prescaler and duration, and increment `o_event_count` (holds at 255).
- FAULT, per cycle:
  - Prescaler counts 0..TICK_DIV-1 and wraps.
  - On wrap, duration increments, saturating at 255.
- FAULT, `i_valid`=1: push the current duration (whole ticks only; a period shorter than one tick records 0) and go to IDLE.
- FIFO: `DEPTH` x 8 bit ring buffer. Read/write pointers have one extra wrap bit. Full and empty come from pointer compare.
- Read strobe path:
  - `i_rd` passes through a two-flop synchroniser plus one edge flop.
  - pop = s2 & ~s3.
  - A pop while empty is ignored.
- Push while full: the new entry is dropped and `o_overflow` is set. Exception: a pop in the same cycle frees a slot first, so the push succeeds and the flag is not set.
- Push and pop in the same cycle while empty: the pop is ignored and the push lands.
- `i_clear` clears the FIFO pointers, `o_event_count`, `o_overflow` and `o_max_dur`. It has priority over push and pop in the same cycle; a coincident push is discarded.
- `i_clear` does not alter the FSM, prescaler or duration. An ongoing FAULT completes normally and pushes afterwards.
- Reset: all state is zeroed and the FSM goes to IDLE. Reset mid-FAULT discards the measurement.

## Timing
- Reset values: `o_fault_active`=0, `o_event_count`=0, `o_data`=0, `o_empty`=1, `o_full`=0, `o_overflow`=0, `o_max_dur`=0.
- `i_valid` sampled 0 at edge E: `o_fault_active` and `o_event_count` update after E.
- Duration is k after k·TICK_DIV cycles spent in FAULT.
- `i_valid` sampled 1 at edge E in FAULT: push at E. `o_data`/`o_empty` reflect it after E, and `o_fault_active` falls after E.
- Glitch handling: an `i_valid` low for one cycle yields one event with duration 0, pushed on the edge after entry.
- `i_rd` rising before edge 0: pop takes effect at edge 2, and `o_data` shows the next entry after edge 2.
- All outputs are registered or decoded directly from registers.

## Configuration
- `FAULT_LOGGER_MAX_HOLD_EN` defined:
  - `o_max_dur` is a register updated on every successful push with max(current, pushed).
  - Cleared by reset or `i_clear`.
- Not defined: `o_max_dur` is tied to 8'd0 and no register is built.

## Test plan
Bench settings: TICK_DIV=4, DEPTH=4.
- Reset check: after reset release, `o_empty`=1, `o_data`=0, `o_event_count`=0.
- `i_valid` low for 10 cycles -> `o_event_count`=1, `o_data`=2 after the push, `o_empty`=0.
- `i_valid` low for 1 cycle -> entry 0; `i_valid` low for 2000 cycles -> entry 255 (saturation).
- Five fault periods (lengths 4, 8, 12, 16, 20 cycles) without reads -> FIFO holds 1, 2, 3, 4; `o_full`=1 and `o_overflow`=1. Four `i_rd` pulses -> reads 1, 2, 3, 4, then `o_empty`=1.
- FIFO full, pop and push on the same edge -> no overflow, `o_full` stays 1, head advances.
- `i_clear` mid-FAULT with 2 entries stored -> FIFO empty and count 0; the fault then ends and pushes its duration. With `FAULT_LOGGER_MAX_HOLD_EN` defined, `o_max_dur` equals that value.

Source files
------------

// File: rtl/fault_logger.sv
// rtl/fault_logger.sv - counts invalid periods, logs their tick durations into a FIFO
// Optional max-duration hold register enabled by FAULT_LOGGER_MAX_HOLD_EN
module fault_logger #(
  parameter logic [15:0] TICK_DIV = 16'd10000,
  parameter int          DEPTH    = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_valid,
  input  logic       i_rd,
  input  logic       i_clear,
  output logic       o_fault_active,
  output logic [7:0] o_event_count,
  output logic [7:0] o_data,
  output logic       o_empty,
  output logic       o_full,
  output logic       o_overflow,
  output logic [7:0] o_max_dur
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE = 1'b0, FAULT = 1'b1} state_t;
  state_t state, state_nxt;

  logic [15:0]   presc;
  logic [7:0]    dur, dur_nxt;
  logic          wrap, enter, push;
  logic [2:0]    rd_sync;
  logic          pop_req, pop_ok, push_ok;
  logic [AW:0]   wr_ptr, rd_ptr;
  logic [7:0]    mem [DEPTH];
  logic [7:0]    event_count;
  logic          overflow;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!i_valid) state_nxt = FAULT;
      FAULT:   if (i_valid)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_fault_active = (state == FAULT);
    enter          = (state == IDLE) && !i_valid;
    push           = (state == FAULT) && i_valid;
  end

  // The push edge still counts as a FAULT cycle, so a wrap on that edge is recorded.
  assign wrap    = (state == FAULT) && (presc == TICK_DIV - 16'd1);
  assign dur_nxt = (wrap && dur != 8'hFF) ? dur + 8'd1 : dur;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      presc <= '0;
      dur   <= '0;
    end else if (enter) begin
      presc <= '0;
      dur   <= '0;
    end else if (state == FAULT) begin
      presc <= wrap ? 16'd0 : presc + 16'd1;
      dur   <= dur_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) rd_sync <= '0;
    else          rd_sync <= {rd_sync[1:0], i_rd};
  end

  assign pop_req = rd_sync[1] && !rd_sync[2];
  assign o_empty = (wr_ptr == rd_ptr);
  assign o_full  = (wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]});
  assign pop_ok  = pop_req && !o_empty;
  // A same-cycle pop frees the slot a full-FIFO push needs.
  assign push_ok = push && (!o_full || pop_ok);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (i_clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (pop_ok)  rd_ptr <= rd_ptr + (AW+1)'(1);
      if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (push_ok && !i_clear) mem[wr_ptr[AW-1:0]] <= dur_nxt;
  end

  assign o_data = o_empty ? 8'd0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      event_count <= '0;
      overflow    <= 1'b0;
    end else if (i_clear) begin
      event_count <= '0;
      overflow    <= 1'b0;
    end else begin
      if (enter && event_count != 8'hFF) event_count <= event_count + 8'd1;
      if (push && !push_ok)              overflow    <= 1'b1;
    end
  end

  assign o_event_count = event_count;
  assign o_overflow    = overflow;

`ifdef FAULT_LOGGER_MAX_HOLD_EN
  logic [7:0] max_dur;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                          max_dur <= '0;
    else if (i_clear)                      max_dur <= '0;
    else if (push_ok && dur_nxt > max_dur) max_dur <= dur_nxt;
  end
  assign o_max_dur = max_dur;
`else
  assign o_max_dur = 8'd0;
`endif

endmodule
